// File: rtl/gsim_pkg.sv
// Shared definitions for the Gauss-Seidel sequencing controller:
// FSM state encoding, tap codes, schedule defaults and the per-tap
// coefficients used by the datapath when it decodes tap_sel.
package gsim_pkg;

    localparam int N_DEFAULT        = 16;
    localparam int MAX_ITER_DEFAULT = 16;
    localparam int ITER_W_DEFAULT   = 5;
    localparam int ROW_W            = 4;
    localparam int TAP_W            = 3;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CLR   = 3'd1,
        FETCH = 3'd2,
        DIV   = 3'd3,
        WB    = 3'd4,
        DONE  = 3'd5
    } state_t;

    // Tap codes: even codes look forward, odd codes look backward
    localparam logic [TAP_W-1:0] TAP_B    = 3'd0;
    localparam logic [TAP_W-1:0] TAP_XM1  = 3'd1;
    localparam logic [TAP_W-1:0] TAP_XP1  = 3'd2;
    localparam logic [TAP_W-1:0] TAP_XM2  = 3'd3;
    localparam logic [TAP_W-1:0] TAP_XP2  = 3'd4;
    localparam logic [TAP_W-1:0] TAP_XM3  = 3'd5;
    localparam logic [TAP_W-1:0] TAP_XP3  = 3'd6;
    localparam logic [TAP_W-1:0] TAP_LAST = TAP_XP3;

    // Band coefficients applied by the MAC for each tap distance
    localparam logic signed [4:0] COEF_B    = 5'sd1;
    localparam logic signed [4:0] COEF_NEAR = 5'sd13;
    localparam logic signed [4:0] COEF_MID  = -5'sd6;
    localparam logic signed [4:0] COEF_FAR  = 5'sd1;

    // Signed row offset selected by a tap code
    function automatic logic signed [4:0] tap_offset(input logic [TAP_W-1:0] tap);
        case (tap)
            TAP_XM1: tap_offset = -5'sd1;
            TAP_XP1: tap_offset = 5'sd1;
            TAP_XM2: tap_offset = -5'sd2;
            TAP_XP2: tap_offset = 5'sd2;
            TAP_XM3: tap_offset = -5'sd3;
            TAP_XP3: tap_offset = 5'sd3;
            default: tap_offset = 5'sd0;
        endcase
    endfunction

    // Coefficient the datapath multiplies a tap operand by
    function automatic logic signed [4:0] tap_coef(input logic [TAP_W-1:0] tap);
        case (tap)
            TAP_B:            tap_coef = COEF_B;
            TAP_XM1, TAP_XP1: tap_coef = COEF_NEAR;
            TAP_XM2, TAP_XP2: tap_coef = COEF_MID;
            TAP_XM3, TAP_XP3: tap_coef = COEF_FAR;
            default:          tap_coef = 5'sd0;
        endcase
    endfunction

endpackage

// File: rtl/gsim_tap_addr.sv
// Combinational (row, tap) -> (rd_addr, op_valid) decode for the banded
// operand fetch. Out-of-band taps report op_valid=0 and address 0.
module gsim_tap_addr
    import gsim_pkg::*;
(
    input  logic [ROW_W-1:0] row,
    input  logic [TAP_W-1:0] tap,
    output logic [ROW_W-1:0] rd_addr,
    output logic             op_valid
);

    logic signed [4:0] offset;
    logic signed [4:0] target;

    // The row is widened to 5-bit signed before the offset is added; a
    // result below 0 is negative, and one above 15 (at most 18) wraps into
    // the negative range, so the sign bit alone flags every out-of-band tap.
    always_comb begin
        offset   = tap_offset(tap);
        target   = $signed({1'b0, row}) + offset;
        op_valid = ~target[4] && (tap <= TAP_LAST);
        rd_addr  = op_valid ? target[ROW_W-1:0] : '0;
    end

endmodule

// File: rtl/gsim_sched.sv
// Gauss-Seidel schedule controller: sweeps rows 0..N-1 for MAX_ITER
// iterations, issuing seven tap fetches per row, a divide request and an
// in-place write-back of x[row].
// Optional build macro GSIM_CONV_EN: adds the conv_small input and ends the
// run early once a complete sweep reports every update below threshold.
module gsim_sched
    import gsim_pkg::*;
#(
    parameter int N        = N_DEFAULT,
    parameter int MAX_ITER = MAX_ITER_DEFAULT,
    parameter int ITER_W   = ITER_W_DEFAULT
)(
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
`ifdef GSIM_CONV_EN
    input  logic              conv_small,
`endif
    output logic              busy,
    output logic              done,
    output logic              acc_clr,
    output logic              op_valid,
    output logic [TAP_W-1:0]  tap_sel,
    output logic [ROW_W-1:0]  rd_addr,
    output logic              div_req,
    input  logic              div_ack,
    output logic              wb_en,
    output logic [ROW_W-1:0]  wb_addr,
    output logic [ITER_W-1:0] iter_cnt
);

    state_t            state;
    state_t            state_nxt;
    logic [ROW_W-1:0]  row;
    logic [TAP_W-1:0]  tap;
    logic [ITER_W-1:0] iter;
    logic [ITER_W-1:0] iter_inc;
    logic              last_row;
    logic              last_iter;
    logic              finish_run;
    logic [ROW_W-1:0]  tap_rd_addr;
    logic              tap_valid;

    assign iter_inc  = iter + ITER_W'(1);
    assign last_row  = (row == ROW_W'(N - 1));
    assign last_iter = (iter_inc == ITER_W'(MAX_ITER));

`ifdef GSIM_CONV_EN
    logic all_small;
    logic sweep_small;

    // Row 0 restarts the sweep-wide flag; later rows AND into it
    assign sweep_small = conv_small && ((row == '0) || all_small);
    assign finish_run  = last_iter || sweep_small;

    // Sticky record of whether every row of the current sweep converged
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            all_small <= 1'b0;
        end else if (state == IDLE && start) begin
            all_small <= 1'b0;
        end else if (state == WB) begin
            all_small <= sweep_small;
        end
    end
`else
    assign finish_run = last_iter;
`endif

    gsim_tap_addr u_tap_addr (
        .row      (row),
        .tap      (tap),
        .rd_addr  (tap_rd_addr),
        .op_valid (tap_valid)
    );

    // FSM state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode and Moore outputs; outputs are idle-valued by default
    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        done      = 1'b0;
        acc_clr   = 1'b0;
        op_valid  = 1'b0;
        tap_sel   = '0;
        rd_addr   = '0;
        div_req   = 1'b0;
        wb_en     = 1'b0;
        wb_addr   = '0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = CLR;
                end
            end
            CLR: begin
                busy      = 1'b1;
                acc_clr   = 1'b1;
                state_nxt = FETCH;
            end
            FETCH: begin
                busy     = 1'b1;
                tap_sel  = tap;
                rd_addr  = tap_rd_addr;
                op_valid = tap_valid;
                if (tap == TAP_LAST) begin
                    state_nxt = DIV;
                end
            end
            DIV: begin
                busy    = 1'b1;
                div_req = 1'b1;
                if (div_ack) begin
                    state_nxt = WB;
                end
            end
            WB: begin
                busy    = 1'b1;
                wb_en   = 1'b1;
                wb_addr = row;
                if (last_row && finish_run) begin
                    state_nxt = DONE;
                end else begin
                    state_nxt = CLR;
                end
            end
            DONE: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Row, tap and iteration counters; they only move in the states that
    // own them, so a stalled divide leaves them frozen
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            row  <= '0;
            tap  <= '0;
            iter <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        row  <= '0;
                        tap  <= '0;
                        iter <= '0;
                    end
                end
                CLR: begin
                    tap <= '0;
                end
                FETCH: begin
                    if (tap != TAP_LAST) begin
                        tap <= tap + TAP_W'(1);
                    end
                end
                WB: begin
                    if (last_row) begin
                        row  <= '0;
                        iter <= iter_inc;
                    end else begin
                        row <= row + ROW_W'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign iter_cnt = iter;

endmodule

// File: tb/tb_gsim_sched.sv
// Directed self-checking bench for gsim_sched. Inputs change and outputs
// are sampled on the falling clock edge.
module tb_gsim_sched;
    import gsim_pkg::*;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic       div_ack;
    logic       busy;
    logic       done;
    logic       acc_clr;
    logic       op_valid;
    logic [2:0] tap_sel;
    logic [3:0] rd_addr;
    logic       div_req;
    logic       wb_en;
    logic [3:0] wb_addr;
    logic [4:0] iter_cnt;
`ifdef GSIM_CONV_EN
    logic       conv_small;
`endif

    logic [21:0] all_out;
    assign all_out = {busy, done, acc_clr, op_valid, tap_sel, rd_addr,
                      div_req, wb_en, wb_addr, iter_cnt};

    int vectors     = 0;
    int miscompares = 0;

    logic       r0_v  [7] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    logic [3:0] r0_a  [7] = '{4'd0, 4'd0, 4'd1, 4'd0, 4'd2, 4'd0, 4'd3};
    logic       r15_v [7] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    logic [3:0] r15_a [7] = '{4'd15, 4'd14, 4'd0, 4'd13, 4'd0, 4'd12, 4'd0};

    gsim_sched dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
`ifdef GSIM_CONV_EN
        .conv_small (conv_small),
`endif
        .busy       (busy),
        .done       (done),
        .acc_clr    (acc_clr),
        .op_valid   (op_valid),
        .tap_sel    (tap_sel),
        .rd_addr    (rd_addr),
        .div_req    (div_req),
        .div_ack    (div_ack),
        .wb_en      (wb_en),
        .wb_addr    (wb_addr),
        .iter_cnt   (iter_cnt)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(negedge clk);
    endtask

    // Drives one run with div_ack tied high; optional extra start pulse at
    // cycle mid_start; reports the cycle of done and the write-back count
    task automatic run_to_done(input int mid_start, output int done_cyc, output int wbs);
        int cyc;
        div_ack  = 1'b1;
        start    = 1'b1;
        step();
        start    = 1'b0;
        cyc      = 1;
        wbs      = 0;
        done_cyc = 0;
        while (cyc < 3000 && done_cyc == 0) begin
            if (done) begin
                done_cyc = cyc;
            end else begin
                if (wb_en) wbs++;
                start = (cyc == mid_start);
                step();
                cyc++;
            end
        end
        start = 1'b0;
        step();
    endtask

    task automatic test_reset();
        reset   = 1'b1;
        start   = 1'b0;
        div_ack = 1'b0;
        step();
        step();
        vectors++;
        if (all_out !== '0) begin
            miscompares++;
            $display("[TB] FAIL reset_outputs: got %h expected 0", all_out);
        end
        reset = 1'b0;
        step();
        step();
        vectors++;
        if (all_out !== '0) begin
            miscompares++;
            $display("[TB] FAIL idle_outputs: got %h expected 0", all_out);
        end
    endtask

    task automatic test_full_run();
        int cyc, pos, ridx, t, wbs, done_cyc;
        logic       exp_v;
        logic [3:0] exp_a;
        div_ack = 1'b1;
        start   = 1'b1;
        step();
        start   = 1'b0;
        cyc     = 1;
        vectors++;
        if (busy !== 1'b1 || acc_clr !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL busy_after_start: got busy=%b acc_clr=%b expected 1 1", busy, acc_clr);
        end
        wbs      = 0;
        done_cyc = 0;
        while (cyc < 3000 && done_cyc == 0) begin
            if (done) begin
                done_cyc = cyc;
            end else begin
                pos  = (cyc - 1) % 10;
                ridx = (cyc - 1) / 10;
                if (wb_en) wbs++;
                if (pos >= 1 && pos <= 7 && (ridx == 0 || ridx == 15)) begin
                    t     = pos - 1;
                    exp_v = (ridx == 0) ? r0_v[t] : r15_v[t];
                    exp_a = (ridx == 0) ? r0_a[t] : r15_a[t];
                    vectors++;
                    if (op_valid !== exp_v || rd_addr !== exp_a || tap_sel !== 3'(t)) begin
                        miscompares++;
                        $display("[TB] FAIL fetch_row%0d_tap%0d: got valid=%b addr=%0d sel=%0d expected %b %0d %0d",
                                 ridx, t, op_valid, rd_addr, tap_sel, exp_v, exp_a, t);
                    end
                end
                if (pos == 9) begin
                    vectors++;
                    if (wb_en !== 1'b1 || wb_addr !== 4'(ridx % 16)) begin
                        miscompares++;
                        $display("[TB] FAIL writeback_cyc%0d: got en=%b addr=%0d expected 1 %0d",
                                 cyc, wb_en, wb_addr, ridx % 16);
                    end
                end
                step();
                cyc++;
            end
        end
        vectors++;
        if (done_cyc != 2561) begin
            miscompares++;
            $display("[TB] FAIL done_cycle: got %0d expected 2561", done_cyc);
        end
        vectors++;
        if (wbs != 256) begin
            miscompares++;
            $display("[TB] FAIL wb_count: got %0d expected 256", wbs);
        end
        vectors++;
        if (iter_cnt !== 5'd16) begin
            miscompares++;
            $display("[TB] FAIL iter_cnt_final: got %0d expected 16", iter_cnt);
        end
        step();
        vectors++;
        if (done !== 1'b0 || busy !== 1'b0 || iter_cnt !== 5'd16) begin
            miscompares++;
            $display("[TB] FAIL after_done: got done=%b busy=%b iter=%0d expected 0 0 16", done, busy, iter_cnt);
        end
    endtask

    task automatic test_div_delay();
        int  cyc, wbs, divcyc, done_cyc;
        logic ack_prev;
        div_ack  = 1'b0;
        start    = 1'b1;
        step();
        start    = 1'b0;
        cyc      = 1;
        wbs      = 0;
        divcyc   = 0;
        done_cyc = 0;
        ack_prev = 1'b0;
        while (cyc < 4000 && done_cyc == 0) begin
            if (done) begin
                done_cyc = cyc;
            end else begin
                if (ack_prev && wbs == 7) begin
                    vectors++;
                    if (wb_en !== 1'b1 || wb_addr !== 4'd7) begin
                        miscompares++;
                        $display("[TB] FAIL wb_after_ack: got en=%b addr=%0d expected 1 7", wb_en, wb_addr);
                    end
                end
                if (div_req && wbs == 7) begin
                    vectors++;
                    if (wb_en !== 1'b0 || acc_clr !== 1'b0 || op_valid !== 1'b0) begin
                        miscompares++;
                        $display("[TB] FAIL div_stall_row7: got wb=%b clr=%b valid=%b expected 0 0 0",
                                 wb_en, acc_clr, op_valid);
                    end
                end
                ack_prev = 1'b0;
                div_ack  = 1'b0;
                if (wb_en) begin
                    if (wbs == 7) begin
                        vectors++;
                        if (divcyc != 4) begin
                            miscompares++;
                            $display("[TB] FAIL div_req_len: got %0d expected 4", divcyc);
                        end
                    end
                    wbs++;
                    divcyc = 0;
                end
                if (div_req) begin
                    divcyc++;
                    if (wbs != 7 || divcyc == 4) begin
                        div_ack  = 1'b1;
                        ack_prev = 1'b1;
                    end
                end
                step();
                cyc++;
            end
        end
        div_ack = 1'b0;
        vectors++;
        if (done_cyc != 2564) begin
            miscompares++;
            $display("[TB] FAIL delayed_done_cycle: got %0d expected 2564", done_cyc);
        end
        vectors++;
        if (wbs != 256) begin
            miscompares++;
            $display("[TB] FAIL delayed_wb_count: got %0d expected 256", wbs);
        end
        step();
    endtask

    task automatic test_start_ignored();
        int done_cyc, wbs;
        // cycle 573 is a FETCH cycle of iteration 3, row 9
        run_to_done(573, done_cyc, wbs);
        vectors++;
        if (done_cyc != 2561 || wbs != 256) begin
            miscompares++;
            $display("[TB] FAIL restart_ignored: got done=%0d wbs=%0d expected 2561 256", done_cyc, wbs);
        end
        vectors++;
        if (iter_cnt !== 5'd16) begin
            miscompares++;
            $display("[TB] FAIL restart_iter: got %0d expected 16", iter_cnt);
        end
    endtask

    task automatic test_reset_mid();
        int cyc, done_cyc, wbs;
        div_ack = 1'b1;
        start   = 1'b1;
        step();
        start   = 1'b0;
        cyc     = 1;
        // DIV of iteration 5, row 0
        while (cyc < 809) begin
            step();
            cyc++;
        end
        vectors++;
        if (div_req !== 1'b1 || iter_cnt !== 5'd5) begin
            miscompares++;
            $display("[TB] FAIL pre_reset_div: got req=%b iter=%0d expected 1 5", div_req, iter_cnt);
        end
        reset = 1'b1;
        step();
        vectors++;
        if (all_out !== '0) begin
            miscompares++;
            $display("[TB] FAIL mid_reset_outputs: got %h expected 0", all_out);
        end
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            vectors++;
            if (all_out !== '0) begin
                miscompares++;
                $display("[TB] FAIL post_reset_idle%0d: got %h expected 0", i, all_out);
            end
        end
        run_to_done(0, done_cyc, wbs);
        vectors++;
        if (done_cyc != 2561 || wbs != 256 || iter_cnt !== 5'd16) begin
            miscompares++;
            $display("[TB] FAIL rerun_after_reset: got done=%0d wbs=%0d iter=%0d expected 2561 256 16",
                     done_cyc, wbs, iter_cnt);
        end
    endtask

`ifdef GSIM_CONV_EN
    task automatic test_conv();
        int cyc, done_cyc;
        div_ack  = 1'b1;
        start    = 1'b1;
        step();
        start    = 1'b0;
        cyc      = 1;
        done_cyc = 0;
        while (cyc < 3000 && done_cyc == 0) begin
            if (done) begin
                done_cyc = cyc;
            end else begin
                conv_small = (iter_cnt == 5'd2);
                step();
                cyc++;
            end
        end
        conv_small = 1'b0;
        vectors++;
        if (done_cyc != 481 || iter_cnt !== 5'd3) begin
            miscompares++;
            $display("[TB] FAIL conv_early_done: got done=%0d iter=%0d expected 481 3", done_cyc, iter_cnt);
        end
        step();
    endtask
`endif

    // Runs every scenario in order and prints the summary
    initial begin
        reset   = 1'b1;
        start   = 1'b0;
        div_ack = 1'b0;
`ifdef GSIM_CONV_EN
        conv_small = 1'b0;
`endif
        $display("[TB] starting gsim_sched bench");
        test_reset();
        test_full_run();
        test_div_delay();
        test_start_ignored();
        test_reset_mid();
`ifdef GSIM_CONV_EN
        test_conv();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
